// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared states, command fields and defaults for the SPI command controller
package spi_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_CMD   = 3'd0;
  localparam state_t S_WDATA = 3'd1;
  localparam state_t S_RPRE  = 3'd2;
  localparam state_t S_RDATA = 3'd3;
  localparam state_t S_DROP  = 3'd4;

  localparam int         CMD_WRITE_BIT = 7;
  localparam logic [7:0] DEF_IDLE_BYTE = 8'hFF;

  function automatic logic cmd_is_write(input logic [7:0] b);
    return b[CMD_WRITE_BIT];
  endfunction

endpackage

// File: rtl/spi_byte_event.sv
// rtl/spi_byte_event.sv - one event per RX_CHANGED rising edge, suppressed while chip select is high
module spi_byte_event (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs,
  input  logic       i_rx_changed,
  input  logic [7:0] i_rx_byte,
  output logic       o_ev,
  output logic [7:0] o_byte
);

  logic       r_chg_q;
  logic [7:0] r_byte;
  logic       w_ev;

  assign w_ev   = i_rx_changed & ~r_chg_q & ~i_cs;
  assign o_ev   = w_ev;
  // Pass the byte straight through on the event cycle so the FSM sees it without delay.
  assign o_byte = w_ev ? i_rx_byte : r_byte;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chg_q <= 1'b0;
      r_byte  <= 8'h00;
    end else begin
      r_chg_q <= i_rx_changed;
      if (w_ev) r_byte <= i_rx_byte;
    end
  end

endmodule

// File: rtl/spi_cmd_controller.sv
// rtl/spi_cmd_controller.sv - parses SPI command/data bytes into auto-incrementing register bus accesses
module spi_cmd_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         AW        = 7,
  parameter int         NREGS     = 128,
  parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cs,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_rx_changed,
  output logic [AW-1:0] o_reg_addr,
  output logic [7:0]    o_reg_wdata,
  output logic          o_reg_we,
  output logic          o_reg_re,
  input  logic [7:0]    i_reg_rdata,
  output logic [7:0]    o_tx_byte,
  output logic          o_busy,
  output logic          o_err
);

  localparam logic [7:0] LP_LAST = 8'(NREGS - 1);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic          r_reg_we;
  logic          r_reg_re;
  logic          r_rd_cap;
  logic [7:0]    r_tx;
  logic          r_busy;
  logic          r_err;

  logic          w_ev;
  logic [7:0]    w_byte;
  logic          w_cmd_bad;
  logic          w_inflight;
  logic [AW-1:0] w_addr_inc;

  spi_byte_event u_byte_event (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cs         (i_cs),
    .i_rx_changed (i_rx_changed),
    .i_rx_byte    (i_rx_byte),
    .o_ev         (w_ev),
    .o_byte       (w_byte)
  );

  // Any nonzero bit above the address field makes the value exceed the last register.
  assign w_cmd_bad  = {1'b0, w_byte[6:0]} > LP_LAST;
  assign w_inflight = r_reg_we | r_reg_re | r_rd_cap;
  assign w_addr_inc = (r_addr == LP_LAST[AW-1:0]) ? '0 : r_addr + AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_CMD;
      r_addr   <= '0;
      r_wdata  <= 8'h00;
      r_reg_we <= 1'b0;
      r_reg_re <= 1'b0;
      r_rd_cap <= 1'b0;
      r_tx     <= IDLE_BYTE;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else if (i_cs) begin
      r_state  <= S_CMD;
      r_reg_we <= 1'b0;
      r_reg_re <= 1'b0;
      r_rd_cap <= 1'b0;
      r_tx     <= IDLE_BYTE;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      r_reg_re <= 1'b0;
      r_rd_cap <= r_reg_re;

      if (r_reg_we) r_addr <= w_addr_inc;

      // Read data is valid the cycle after the strobe; capture completes even after an abort to S_DROP.
      if (r_rd_cap) begin
        r_tx   <= i_reg_rdata;
        r_addr <= w_addr_inc;
        if (r_state == S_RPRE) r_state <= S_RDATA;
      end

      if (w_ev) begin
        case (r_state)
          S_CMD: begin
            if (w_byte != IDLE_BYTE) begin
              if (w_cmd_bad) begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end else begin
                r_addr <= w_byte[AW-1:0];
                r_busy <= 1'b1;
                if (cmd_is_write(w_byte)) begin
                  r_state <= S_WDATA;
                end else begin
                  r_reg_re <= 1'b1;
                  r_state  <= S_RPRE;
                end
              end
            end
          end
          S_WDATA: begin
            if (w_inflight) begin
              r_err   <= 1'b1;
              r_state <= S_DROP;
            end else begin
              r_wdata  <= w_byte;
              r_reg_we <= 1'b1;
            end
          end
          S_RPRE: begin
            r_err   <= 1'b1;
            r_state <= S_DROP;
          end
          S_RDATA: begin
            r_reg_re <= 1'b1;
            r_state  <= S_RPRE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_reg_re    = r_reg_re;
  assign o_tx_byte   = r_tx;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb/tb_spi_cmd_controller.sv - scoreboard bench for spi_cmd_controller with directed byte frames
module tb_spi_cmd_controller;

  localparam int AW    = 4;
  localparam int NREGS = 8;

  typedef struct packed {
    logic [3:0]  a;
    logic [7:0]  d;
    logic [31:0] t;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [7:0]    rx_byte;
  logic          rx_changed;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic [7:0]    tx_byte;
  logic          busy;
  logic          err;

  logic [7:0] regs [16];
  ent_t wr_q[$];
  ent_t rd_q[$];
  ent_t tx_q[$];
  int total = 0;
  int bad = 0;
  int n_neg = 0;
  logic [7:0] prev_tx = 8'hFF;
  logic [7:0] model_tx = 8'hFF;

  spi_cmd_controller #(.AW(AW), .NREGS(NREGS), .IDLE_BYTE(8'hFF)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cs         (cs),
    .i_rx_byte    (rx_byte),
    .i_rx_changed (rx_changed),
    .o_reg_addr   (reg_addr),
    .o_reg_wdata  (reg_wdata),
    .o_reg_we     (reg_we),
    .o_reg_re     (reg_re),
    .i_reg_rdata  (reg_rdata),
    .o_tx_byte    (tx_byte),
    .o_busy       (busy),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_we) regs[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= regs[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    n_neg = n_neg + 1;
    if (!rst) begin
      if (reg_we || reg_re) chk("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        if (wr_q.size() == 0) chk("unexpected_we", {24'd0, reg_wdata}, 32'hFFFF_FFFF);
        else begin
          e = wr_q.pop_front();
          chk("we_addr", 32'(reg_addr), 32'(e.a));
          chk("we_data", 32'(reg_wdata), 32'(e.d));
          chk("we_cycle", n_neg, e.t);
        end
      end
      if (reg_re) begin
        if (rd_q.size() == 0) chk("unexpected_re", 32'(reg_addr), 32'hFFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          chk("re_addr", 32'(reg_addr), 32'(e.a));
          chk("re_cycle", n_neg, e.t);
        end
      end
      if (tx_byte !== prev_tx) begin
        if (tx_q.size() == 0) chk("unexpected_tx", 32'(tx_byte), 32'hFFFF_FFFF);
        else begin
          e = tx_q.pop_front();
          chk("tx_data", 32'(tx_byte), 32'(e.d));
          chk("tx_cycle", n_neg, e.t);
        end
      end
      prev_tx = tx_byte;
    end
  end

  // mode: 0 = no bus access expected, 1 = write of ed to ea, 2 = read of ea returning ed
  task automatic send(input logic [7:0] b, input int hold, input int gap,
                      input int mode, input logic [3:0] ea, input logic [7:0] ed);
    int t;
    t = n_neg;
    if (mode == 1) wr_q.push_back(ent_t'{a: ea, d: ed, t: 32'(t + 2)});
    if (mode == 2) begin
      rd_q.push_back(ent_t'{a: ea, d: 8'h00, t: 32'(t + 2)});
      tx_q.push_back(ent_t'{a: 4'h0, d: ed, t: 32'(t + 4)});
      model_tx = ed;
    end
    rx_byte = b;
    rx_changed = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_changed = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic cs_close();
    int t;
    t = n_neg;
    if (model_tx != 8'hFF) begin
      tx_q.push_back(ent_t'{a: 4'h0, d: 8'hFF, t: 32'(t + 2)});
      model_tx = 8'hFF;
    end
    cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 cs = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[3] = 8'hA5;
    regs[4] = 8'h5A;
    reg_rdata = 8'h00;
    rst = 1'b1;
    cs = 1'b0;
    rx_byte = 8'h00;
    rx_changed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_re", 32'(reg_re), 32'd0);
    chk("rst_tx", 32'(tx_byte), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    send(8'h85, 3, 3, 0, 4'h0, 8'h00);
    send(8'h11, 3, 3, 1, 4'h5, 8'h11);
    send(8'h22, 3, 3, 1, 4'h6, 8'h22);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_err", 32'(err), 32'd0);
    cs_close();
    chk("wr_close_busy", 32'(busy), 32'd0);

    send(8'h03, 3, 3, 2, 4'h3, 8'hA5);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_addr_inc", 32'(reg_addr), 32'd4);
    send(8'hFF, 3, 3, 2, 4'h4, 8'h5A);
    cs_close();

    send(8'h87, 3, 3, 0, 4'h0, 8'h00);
    send(8'hC1, 3, 3, 1, 4'h7, 8'hC1);
    send(8'hC2, 3, 3, 1, 4'h0, 8'hC2);
    chk("wrap_err", 32'(err), 32'd0);
    cs_close();

    send(8'h8A, 3, 3, 0, 4'h0, 8'h00);
    chk("bad_cmd_err", 32'(err), 32'd1);
    chk("bad_cmd_busy", 32'(busy), 32'd0);
    send(8'h44, 3, 3, 0, 4'h0, 8'h00);
    send(8'h55, 3, 3, 0, 4'h0, 8'h00);
    chk("drop_err_sticky", 32'(err), 32'd1);
    cs_close();
    chk("cs_clears_err", 32'(err), 32'd0);
    chk("cs_clears_busy", 32'(busy), 32'd0);

    send(8'h82, 3, 3, 0, 4'h0, 8'h00);
    send(8'h33, 3, 3, 1, 4'h2, 8'h33);
    cs = 1'b1;
    rx_byte = 8'h99;
    rx_changed = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_changed = 1'b0;
    @(posedge clk);
    #1 cs = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    send(8'h84, 3, 3, 0, 4'h0, 8'h00);
    send(8'h66, 3, 3, 1, 4'h4, 8'h66);
    chk("new_frame_busy", 32'(busy), 32'd1);
    chk("new_frame_err", 32'(err), 32'd0);
    cs_close();

    send(8'h02, 1, 1, 2, 4'h2, 8'h33);
    send(8'h00, 1, 4, 0, 4'h0, 8'h00);
    chk("inflight_err", 32'(err), 32'd1);
    cs_close();

    repeat (5) @(posedge clk);
    #1;
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Sequences the SPI receive byte buffer and turns its byte stream into register-bank transactions.
- Parses a command byte and then a run of data bytes, and drives a simple register bus with auto-increment.
- Provides the next transmit byte for reads.
- Sits between the SPI receive buffer (RX_BYTE/RX_CHANGED) and the local register file; single clock domain.

Parameters:
- AW, 7: register address width, 1..7.
- NREGS, 128: number of implemented registers, 1..2^AW.
- IDLE_BYTE, 8'hFF: fill byte; ignored as a command, and the reset/idle value of TX_BYTE.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CS  in  1  chip select, active-high = deselected; high aborts the frame.
- RX_BYTE  in  8  last completed byte from the SPI buffer.
- RX_CHANGED  in  1  high for >=1 cycle after each new byte; may stay high several cycles.
- REG_ADDR  out  AW  register bus address.
- REG_WDATA  out  8  register write data.
- REG_WE  out  1  one-cycle write strobe.
- REG_RE  out  1  one-cycle read strobe.
- REG_RDATA  in  8  read data, valid the cycle after REG_RE.
- TX_BYTE  out  8  byte to shift out on the next SPI byte slot.
- BUSY  out  1  high while a frame is open (a command has been accepted).
- ERR  out  1  sticky per-frame error; cleared by CS high or RST.

Behaviour:
- Reset (RST=1 at a CLK edge): state=S_CMD, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, TX_BYTE=IDLE_BYTE, BUSY=0, ERR=0, edge register=0. Reset overrides every other input.
- Byte event: ev = RX_CHANGED & ~chg_q & ~CS. chg_q is RX_CHANGED registered. One event per rising edge of RX_CHANGED, regardless of how long it stays high.
- CS high in any cycle: next state S_CMD, BUSY=0, ERR=0, TX_BYTE=IDLE_BYTE, no strobes issued. CS high in the same cycle as RX_CHANGED rising: byte discarded.
- Command byte: bit7=1 means write, bit7=0 means read; bits[AW-1:0] are the start address; bits[6:AW] must be 0.
- S_CMD, on ev:
  - RX_BYTE==IDLE_BYTE: ignored, stay in S_CMD.
  - Address >= NREGS or nonzero bits[6:AW]: ERR=1, go to S_DROP.
  - Write: latch address, BUSY=1, go to S_WDATA.
  - Read: latch address, BUSY=1, go to S_RPRE.
- S_WDATA, on ev:
  - Cycle ev+1: REG_WDATA=RX_BYTE, REG_WE=1 for exactly one cycle with REG_ADDR = current address.
  - Cycle ev+2: address increments.
- S_RPRE (also entered after each read-mode ev):
  - Cycle +1: REG_RE=1 for one cycle.
  - Cycle +2: REG_RDATA captured into TX_BYTE, address increments, go to S_RDATA.
  - Total latency from ev to TX_BYTE update: 3 cycles.
- S_RDATA, on ev: the received byte is a dummy and is not written; go to S_RPRE to prefetch the next register.
- Address wrap: increment from NREGS-1 goes to 0 with no error.
- S_DROP: all events ignored; only CS high or RST leaves.
- An ev arriving while a strobe sequence is still in progress (in-flight): ERR=1, go to S_DROP. The in-flight access completes.
- REG_WE and REG_RE are never high in the same cycle.

Decomposition:
- Package spi_ctrl_pkg:
  - state enum {S_CMD, S_WDATA, S_RPRE, S_RDATA, S_DROP}
  - CMD_WRITE_BIT=7
  - default IDLE_BYTE
- Sub-module spi_byte_event: RX_CHANGED edge detector gated by CS; outputs ev and the latched byte.

Test Plan:
- RST, then idle for 10 cycles -> all outputs at reset values; TX_BYTE=8'hFF.
- Bytes 0x85, 0x11, 0x22 (RX_CHANGED held 3 cycles each) -> REG_WE pulses at addr 5 with data 0x11, then addr 6 with 0x22; exactly two pulses; BUSY=1.
- Bytes 0x03, 0xFF, 0xFF with regs[3]=0xA5, regs[4]=0x5A -> REG_RE at addr 3, TX_BYTE=0xA5 three cycles after the first ev; then TX_BYTE=0x5A after the next ev.
- NREGS=8; write to addr 7 followed by 2 data bytes -> writes land at addr 7 then 0; ERR=0.
- Command 0x8A with NREGS=8 -> ERR=1; later data bytes produce no REG_WE; CS high clears ERR and BUSY.
- CS high mid-write, in the same cycle as an RX_CHANGED rise -> no REG_WE; the next frame parses its first byte as a command.
